// File: rtl/id_ex_pipeline_register.sv
// ID/EX boundary register: captures decoded operands and control, inserts a
// single bubble on a load-use dependency, and honours downstream stall and flush.
module id_ex_pipeline_register #(
  parameter int data_width    = 16,
  parameter int address_width = 3,
  parameter int ctrl_width    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [data_width-1:0]    id_read_data1,
  input  logic [data_width-1:0]    id_read_data2,
  input  logic [data_width-1:0]    id_imm,
  input  logic [address_width-1:0] id_src1,
  input  logic [address_width-1:0] id_src2,
  input  logic                     id_src1_used,
  input  logic                     id_src2_used,
  input  logic [address_width-1:0] id_dest,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic [ctrl_width-1:0]    id_ctrl,
  input  logic                     flush,
  input  logic                     ex_stall,
  output logic                     ex_valid,
  output logic [data_width-1:0]    ex_read_data1,
  output logic [data_width-1:0]    ex_read_data2,
  output logic [data_width-1:0]    ex_imm,
  output logic [address_width-1:0] ex_dest,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic [ctrl_width-1:0]    ex_ctrl,
  output logic                     id_hold,
  output logic [7:0]               bubble_count
);

  logic                     valid_q, valid_d;
  logic [data_width-1:0]    rd1_q, rd1_d;
  logic [data_width-1:0]    rd2_q, rd2_d;
  logic [data_width-1:0]    imm_q, imm_d;
  logic [address_width-1:0] dest_q, dest_d;
  logic                     reg_write_q, reg_write_d;
  logic                     mem_read_q, mem_read_d;
  logic [ctrl_width-1:0]    ctrl_q, ctrl_d;
  logic [7:0]               bubble_count_q, bubble_count_d;
  logic                     hazard;

  // Only a valid load in EX can create a dependency; register 0 is an ordinary register.
  always_comb begin
    hazard = id_valid & valid_q & mem_read_q & reg_write_q &
             ((id_src1_used & (id_src1 == dest_q)) |
              (id_src2_used & (id_src2 == dest_q)));
    id_hold = !flush & (ex_stall | hazard);
  end

  always_comb begin
    valid_d        = valid_q;
    rd1_d          = rd1_q;
    rd2_d          = rd2_q;
    imm_d          = imm_q;
    dest_d         = dest_q;
    reg_write_d    = reg_write_q;
    mem_read_d     = mem_read_q;
    ctrl_d         = ctrl_q;
    bubble_count_d = bubble_count_q;
    if (flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      ctrl_d      = '0;
    end else if (ex_stall) begin
      valid_d = valid_q;
    end else if (hazard) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      ctrl_d      = '0;
      if (bubble_count_q != 8'hFF) begin
        bubble_count_d = bubble_count_q + 8'd1;
      end
    end else begin
      valid_d     = id_valid;
      rd1_d       = id_read_data1;
      rd2_d       = id_read_data2;
      imm_d       = id_imm;
      dest_d      = id_dest;
      // An empty decode slot must not carry live control into EX.
      reg_write_d = id_valid & id_reg_write;
      mem_read_d  = id_valid & id_mem_read;
      ctrl_d      = id_valid ? id_ctrl : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q        <= 1'b0;
      rd1_q          <= '0;
      rd2_q          <= '0;
      imm_q          <= '0;
      dest_q         <= '0;
      reg_write_q    <= 1'b0;
      mem_read_q     <= 1'b0;
      ctrl_q         <= '0;
      bubble_count_q <= 8'd0;
    end else begin
      valid_q        <= valid_d;
      rd1_q          <= rd1_d;
      rd2_q          <= rd2_d;
      imm_q          <= imm_d;
      dest_q         <= dest_d;
      reg_write_q    <= reg_write_d;
      mem_read_q     <= mem_read_d;
      ctrl_q         <= ctrl_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_read_data1 = rd1_q;
  assign ex_read_data2 = rd2_q;
  assign ex_imm        = imm_q;
  assign ex_dest       = dest_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_ctrl       = ctrl_q;
  assign bubble_count  = bubble_count_q;

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Bench for id_ex_pipeline_register: directed vector table, hand sequences for
// reset/stall/flush/saturation, then random traffic against a reference model.
module tb_id_ex_pipeline_register;

  logic        clk, rst;
  logic        id_valid, id_src1_used, id_src2_used, id_reg_write, id_mem_read;
  logic [15:0] id_read_data1, id_read_data2, id_imm;
  logic [2:0]  id_src1, id_src2, id_dest;
  logic [7:0]  id_ctrl;
  logic        flush, ex_stall;
  logic        ex_valid, ex_reg_write, ex_mem_read, id_hold;
  logic [15:0] ex_read_data1, ex_read_data2, ex_imm;
  logic [2:0]  ex_dest;
  logic [7:0]  ex_ctrl, bubble_count;

  int checks = 0;
  int errors = 0;

  id_ex_pipeline_register dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_read_data1(id_read_data1), .id_read_data2(id_read_data2), .id_imm(id_imm),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
    .id_dest(id_dest), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_ctrl(id_ctrl), .flush(flush), .ex_stall(ex_stall),
    .ex_valid(ex_valid), .ex_read_data1(ex_read_data1), .ex_read_data2(ex_read_data2),
    .ex_imm(ex_imm), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_ctrl(ex_ctrl), .id_hold(id_hold),
    .bubble_count(bubble_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        v;
    logic [15:0] d1, d2, imm;
    logic [2:0]  s1, s2;
    logic        s1u, s2u;
    logic [2:0]  dest;
    logic        rw, mr;
    logic [7:0]  ctrl;
    logic        flush, stall;
  } in_t;

  // Architectural view of the EX slot; bubbles counted without bound and saturated on compare.
  typedef struct {
    logic        v;
    logic [15:0] d1, d2, imm;
    logic [2:0]  dest;
    logic        rw, mr;
    logic [7:0]  ctrl;
    int          bubbles;
  } ex_t;

  typedef struct {
    in_t         i;
    logic        hold, v;
    logic [15:0] d1;
    logic [2:0]  dest;
    logic        rw, mr;
    logic [7:0]  ctrl, bc;
  } vec_t;

  ex_t  m;
  vec_t tbl [11];

  function automatic in_t mk(logic v, logic [15:0] d1, logic [15:0] d2, logic [15:0] imm,
                             logic [2:0] s1, logic s1u, logic [2:0] s2, logic s2u,
                             logic [2:0] dest, logic rw, logic mr, logic [7:0] ctrl,
                             logic fl, logic st);
    in_t x;
    x.v = v; x.d1 = d1; x.d2 = d2; x.imm = imm; x.s1 = s1; x.s1u = s1u;
    x.s2 = s2; x.s2u = s2u; x.dest = dest; x.rw = rw; x.mr = mr; x.ctrl = ctrl;
    x.flush = fl; x.stall = st;
    return x;
  endfunction

  function automatic vec_t row(in_t i, logic hold, logic v, logic [15:0] d1, logic [2:0] dest,
                               logic rw, logic mr, logic [7:0] ctrl, logic [7:0] bc);
    vec_t r;
    r.i = i; r.hold = hold; r.v = v; r.d1 = d1; r.dest = dest;
    r.rw = rw; r.mr = mr; r.ctrl = ctrl; r.bc = bc;
    return r;
  endfunction

  function automatic logic reads_reg(in_t x, logic [2:0] r);
    return (x.s1u && x.s1 == r) || (x.s2u && x.s2 == r);
  endfunction

  function automatic logic load_use(ex_t s, in_t x);
    return x.v && s.v && s.mr && s.rw && reads_reg(x, s.dest);
  endfunction

  function automatic logic exp_hold(ex_t s, in_t x);
    if (x.flush) return 1'b0;
    return x.stall || load_use(s, x);
  endfunction

  function automatic ex_t advance(ex_t s, in_t x);
    ex_t n = s;
    if (x.flush) begin
      n.v = 0; n.rw = 0; n.mr = 0; n.ctrl = 0;
    end else if (x.stall) begin
      n = s;
    end else if (load_use(s, x)) begin
      n.v = 0; n.rw = 0; n.mr = 0; n.ctrl = 0;
      n.bubbles = s.bubbles + 1;
    end else begin
      n.v = x.v; n.d1 = x.d1; n.d2 = x.d2; n.imm = x.imm; n.dest = x.dest;
      n.rw = x.v ? x.rw : 1'b0;
      n.mr = x.v ? x.mr : 1'b0;
      n.ctrl = x.v ? x.ctrl : 8'h00;
    end
    return n;
  endfunction

  function automatic logic [7:0] sat(int b);
    return (b > 255) ? 8'd255 : b[7:0];
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(in_t x);
    id_valid = x.v; id_read_data1 = x.d1; id_read_data2 = x.d2; id_imm = x.imm;
    id_src1 = x.s1; id_src2 = x.s2; id_src1_used = x.s1u; id_src2_used = x.s2u;
    id_dest = x.dest; id_reg_write = x.rw; id_mem_read = x.mr; id_ctrl = x.ctrl;
    flush = x.flush; ex_stall = x.stall;
  endtask

  task automatic model_reset();
    m.v = 0; m.d1 = 0; m.d2 = 0; m.imm = 0; m.dest = 0;
    m.rw = 0; m.mr = 0; m.ctrl = 0; m.bubbles = 0;
  endtask

  // Drives one instruction slot: id_hold sampled at negedge, registers sampled 1ns after posedge.
  task automatic cycle(in_t x, string tag);
    drive(x);
    @(negedge clk);
    chk({tag, " id_hold"}, {31'd0, id_hold}, {31'd0, exp_hold(m, x)});
    @(posedge clk);
    m = advance(m, x);
    #1;
  endtask

  task automatic chk_model(string tag);
    chk({tag, " ex_valid"}, {31'd0, ex_valid}, {31'd0, m.v});
    chk({tag, " ex_reg_write"}, {31'd0, ex_reg_write}, {31'd0, m.rw});
    chk({tag, " ex_mem_read"}, {31'd0, ex_mem_read}, {31'd0, m.mr});
    chk({tag, " ex_ctrl"}, {24'd0, ex_ctrl}, {24'd0, m.ctrl});
    chk({tag, " bubble_count"}, {24'd0, bubble_count}, {24'd0, sat(m.bubbles)});
    chk({tag, " ex_read_data1"}, {16'd0, ex_read_data1}, {16'd0, m.d1});
    chk({tag, " ex_read_data2"}, {16'd0, ex_read_data2}, {16'd0, m.d2});
    chk({tag, " ex_imm"}, {16'd0, ex_imm}, {16'd0, m.imm});
    chk({tag, " ex_dest"}, {29'd0, ex_dest}, {29'd0, m.dest});
  endtask

  task automatic step(in_t x, string tag);
    cycle(x, tag);
    chk_model(tag);
  endtask

  initial begin
    in_t x;
    logic [15:0] snap_d1;
    logic [7:0]  snap_ctrl, snap_bc;
    logic [2:0]  snap_dest;

    tbl[0]  = row(mk(1,16'h1234,16'hABCD,16'h0007,3'd1,1,3'd2,1,3'd5,1,0,8'h3C,0,0), 0,1,16'h1234,3'd5,1,0,8'h3C,8'd0);
    tbl[1]  = row(mk(1,16'h1111,16'h0001,16'h0002,3'd5,1,3'd5,0,3'd3,1,1,8'hA5,0,0), 0,1,16'h1111,3'd3,1,1,8'hA5,8'd0);
    tbl[2]  = row(mk(1,16'h2222,16'h0003,16'h0004,3'd3,1,3'd1,0,3'd4,1,0,8'h0F,0,0), 1,0,16'h1111,3'd3,0,0,8'h00,8'd1);
    tbl[3]  = row(mk(1,16'h2222,16'h0003,16'h0004,3'd3,1,3'd1,0,3'd4,1,0,8'h0F,0,0), 0,1,16'h2222,3'd4,1,0,8'h0F,8'd1);
    tbl[4]  = row(mk(1,16'h3333,16'h0000,16'h0000,3'd4,1,3'd0,0,3'd6,1,1,8'hC3,0,0), 0,1,16'h3333,3'd6,1,1,8'hC3,8'd1);
    tbl[5]  = row(mk(1,16'h4444,16'h0000,16'h0000,3'd6,0,3'd6,0,3'd7,1,0,8'h11,0,0), 0,1,16'h4444,3'd7,1,0,8'h11,8'd1);
    tbl[6]  = row(mk(1,16'h5555,16'h0000,16'h0000,3'd7,1,3'd7,1,3'd1,1,1,8'h22,0,1), 1,1,16'h4444,3'd7,1,0,8'h11,8'd1);
    tbl[7]  = row(mk(1,16'h6666,16'h0000,16'h0000,3'd7,1,3'd0,0,3'd2,1,0,8'h33,1,0), 0,0,16'h4444,3'd7,0,0,8'h00,8'd1);
    tbl[8]  = row(mk(0,16'h7777,16'h0000,16'h0000,3'd0,0,3'd0,0,3'd2,1,1,8'hFF,0,0), 0,0,16'h7777,3'd2,0,0,8'h00,8'd1);
    tbl[9]  = row(mk(1,16'h0800,16'h0000,16'h0000,3'd1,0,3'd1,0,3'd0,1,1,8'h01,0,0), 0,1,16'h0800,3'd0,1,1,8'h01,8'd1);
    tbl[10] = row(mk(1,16'h0900,16'h0000,16'h0000,3'd5,1,3'd0,1,3'd6,1,0,8'h02,0,0), 1,0,16'h0800,3'd0,0,0,8'h00,8'd2);

    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_model("reset");

    for (int k = 0; k < 11; k++) begin
      string t;
      t = $sformatf("vec%0d", k);
      drive(tbl[k].i);
      @(negedge clk);
      chk({t, " id_hold"}, {31'd0, id_hold}, {31'd0, tbl[k].hold});
      @(posedge clk);
      m = advance(m, tbl[k].i);
      #1;
      chk({t, " ex_valid"}, {31'd0, ex_valid}, {31'd0, tbl[k].v});
      chk({t, " ex_read_data1"}, {16'd0, ex_read_data1}, {16'd0, tbl[k].d1});
      chk({t, " ex_dest"}, {29'd0, ex_dest}, {29'd0, tbl[k].dest});
      chk({t, " ex_reg_write"}, {31'd0, ex_reg_write}, {31'd0, tbl[k].rw});
      chk({t, " ex_mem_read"}, {31'd0, ex_mem_read}, {31'd0, tbl[k].mr});
      chk({t, " ex_ctrl"}, {24'd0, ex_ctrl}, {24'd0, tbl[k].ctrl});
      chk({t, " bubble_count"}, {24'd0, bubble_count}, {24'd0, tbl[k].bc});
      $display("vec%0d hold=%0b ex_valid=%0b rd1=%h dest=%0d ctrl=%h bc=%0d",
               k, id_hold, ex_valid, ex_read_data1, ex_dest, ex_ctrl, bubble_count);
    end

    // Asynchronous reset mid-cycle with a valid instruction in EX.
    step(mk(1,16'hBEEF,16'h1,16'h2,3'd0,0,3'd0,0,3'd2,1,0,8'h5A,0,0), "pre_rst");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("async_rst ex_ctrl", {24'd0, ex_ctrl}, 32'd0);
    chk("async_rst bubble_count", {24'd0, bubble_count}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_edge ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_edge ex_read_data1", {16'd0, ex_read_data1}, 32'd0);
    rst = 1'b0;
    model_reset();
    $display("async reset ex_valid=%0b bc=%0d", ex_valid, bubble_count);

    // Three stall cycles with a load in EX and a dependent decode, then flush against the hazard.
    step(mk(1,16'hC0DE,16'h2,16'h3,3'd0,0,3'd0,0,3'd3,1,1,8'h77,0,0), "load3");
    snap_d1 = ex_read_data1; snap_ctrl = ex_ctrl; snap_dest = ex_dest; snap_bc = bubble_count;
    for (int k = 0; k < 3; k++) begin
      x = mk(1,16'($urandom),16'($urandom),16'($urandom),3'd3,1,3'd0,0,3'd4,1,0,8'($urandom),0,1);
      step(x, $sformatf("stall%0d", k));
      chk("stall hold_seen", {31'd0, id_hold}, 32'd1);
      chk("stall ex_read_data1", {16'd0, ex_read_data1}, {16'd0, snap_d1});
      chk("stall ex_ctrl", {24'd0, ex_ctrl}, {24'd0, snap_ctrl});
      chk("stall ex_dest", {29'd0, ex_dest}, {29'd0, snap_dest});
      chk("stall bubble_count", {24'd0, bubble_count}, {24'd0, snap_bc});
      $display("stall%0d hold=%0b ex_valid=%0b ctrl=%h bc=%0d", k, id_hold, ex_valid, ex_ctrl, bubble_count);
    end
    x = mk(1,16'h9999,16'h0,16'h0,3'd3,1,3'd0,0,3'd4,1,0,8'h44,1,0);
    drive(x);
    #1;
    chk("flush+hazard id_hold", {31'd0, id_hold}, 32'd0);
    step(x, "flush_hz");
    chk("flush+hazard ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush+hazard bubble_count", {24'd0, bubble_count}, {24'd0, snap_bc});
    $display("flush+hazard hold=%0b ex_valid=%0b bc=%0d", id_hold, ex_valid, bubble_count);

    // Stall concurrent with a hazard: hold, no bubble.
    step(mk(1,16'h0101,16'h0,16'h0,3'd0,0,3'd0,0,3'd3,1,1,8'h10,0,0), "load3b");
    step(mk(1,16'h0202,16'h0,16'h0,3'd0,0,3'd3,1,3'd1,1,0,8'h20,0,1), "stall_hz");
    chk("stall+hazard id_hold", {31'd0, id_hold}, 32'd1);
    chk("stall+hazard ex_valid", {31'd0, ex_valid}, 32'd1);
    chk("stall+hazard bubble_count", {24'd0, bubble_count}, {24'd0, snap_bc});
    $display("stall+hazard hold=%0b ex_valid=%0b bc=%0d", id_hold, ex_valid, bubble_count);

    // Saturation: a self-dependent load alternates load / bubble, 260 bubbles in total.
    rst = 1'b1;
    model_reset();
    #1;
    rst = 1'b0;
    x = mk(1,16'h0F0F,16'h0,16'h0,3'd3,1,3'd0,0,3'd3,1,1,8'h81,0,0);
    for (int k = 0; k < 520; k++) step(x, "sat");
    chk("saturation bubble_count", {24'd0, bubble_count}, 32'd255);
    for (int k = 0; k < 6; k++) step(x, "sat_hold");
    chk("saturation stays", {24'd0, bubble_count}, 32'd255);
    $display("saturation bubbles=%0d bubble_count=%0d", m.bubbles, bubble_count);

    // Random traffic with a small register space so load-use hits are frequent.
    rst = 1'b1;
    model_reset();
    #1;
    rst = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      x = mk(($urandom_range(3) != 0), 16'($urandom), 16'($urandom), 16'($urandom),
             3'($urandom_range(7)), 1'($urandom), 3'($urandom_range(7)), 1'($urandom),
             3'($urandom_range(7)), 1'($urandom), 1'($urandom), 8'($urandom),
             ($urandom_range(7) == 0), ($urandom_range(3) == 0));
      step(x, $sformatf("rnd%0d", k));
      if (k % 100 == 0)
        $display("rnd%0d hold=%0b ex_valid=%0b dest=%0d mr=%0b bc=%0d",
                 k, id_hold, ex_valid, ex_dest, ex_mem_read, bubble_count);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_pipeline_register.md
Name: id_ex_pipeline_register

Overview:
- Decode→execute boundary register of the five-stage pipeline.
- Captures the register-file read data, immediate, destination and control from decode.
- Detects load-use hazards against the instruction currently in EX, inserts one bubble, and holds IF/ID.
- Honours downstream stall and branch flush.

Parameters:
- data_width, 16, width of operands and immediate.
- address_width, 3, register address width (8 registers).
- ctrl_width, 8, opaque EX/MEM/WB control bundle width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  decode slot holds a real instruction.
- id_read_data1  in  data_width  operand 1 from register file (stable at posedge).
- id_read_data2  in  data_width  operand 2 from register file.
- id_imm  in  data_width  sign-extended immediate.
- id_src1  in  address_width  source register 1 address.
- id_src2  in  address_width  source register 2 address.
- id_src1_used  in  1  instruction actually reads src1.
- id_src2_used  in  1  instruction actually reads src2.
- id_dest  in  address_width  destination register.
- id_reg_write  in  1  instruction writes back.
- id_mem_read  in  1  instruction is a load.
- id_ctrl  in  ctrl_width  remaining control bits.
- flush  in  1  branch taken; kill the instruction in decode.
- ex_stall  in  1  downstream busy; hold EX contents.
- ex_valid  out  1  EX slot valid.
- ex_read_data1, ex_read_data2, ex_imm  out  data_width  registered operands.
- ex_dest  out  address_width  registered destination.
- ex_reg_write, ex_mem_read  out  1  registered control.
- ex_ctrl  out  ctrl_width  registered control bundle.
- id_hold  out  1  combinational; IF/ID must not advance.
- bubble_count  out  8  saturating count of load-use bubbles inserted.

Behaviour:
- Reset (async, rst=1): all ex_* outputs = 0, ex_valid = 0, bubble_count = 0. Takes effect immediately, including mid-stall. No update occurs on the posedge where rst is still high.
- hazard (combinational) = id_valid & ex_valid & ex_mem_read & ex_reg_write & ((id_src1_used & id_src1==ex_dest) | (id_src2_used & id_src2==ex_dest)).
- id_hold = !flush & (ex_stall | hazard).
- Posedge update priority:
  - 1) flush: ex_valid←0; ex_reg_write, ex_mem_read, ex_ctrl ← 0; data fields don't-care (hold).
  - 2) ex_stall: every ex_* register holds its value.
  - 3) hazard: bubble. ex_valid←0, control fields←0, data fields hold. bubble_count increments by 1, saturating at 255.
  - 4) else: load all id_* fields. ex_valid←id_valid. If id_valid=0, the control fields are loaded as 0.
- Latency: exactly one cycle from decode inputs to ex_* outputs.
- Load-use costs exactly one bubble: after the bubble, ex_valid=0, so hazard deasserts and the held decode instruction loads on the next edge.
- Register writeback is visible to decode in the same cycle because of the register file's write-then-read phases. No WB bypass is required here.
- Simultaneous flush and hazard: flush wins, no bubble is counted, and id_hold=0.
- Simultaneous ex_stall and hazard: hold (no bubble, no count); id_hold=1.
- A hazard is evaluated only against a valid EX load. A non-load or an invalid EX never stalls.
- Address match includes register 0; there is no hardwired-zero register.

Test Plan:
- Reset: assert rst mid-cycle with ex_valid=1 → ex_valid=0, ex_ctrl=0, bubble_count=0 before the next posedge.
- Normal flow: id_valid=1, rd1=0x1234, rd2=0xABCD, dest=5, ctrl=0x3C → next posedge ex_read_data1=0x1234, ex_read_data2=0xABCD, ex_dest=5, ex_ctrl=0x3C, ex_valid=1, id_hold=0.
- Load-use: EX holds a load (mem_read=1, reg_write=1, dest=3); ID has src1=3, src1_used=1 → id_hold=1 that cycle. Next edge: ex_valid=0, bubble_count=1. Following edge: ID instruction loads, ex_valid=1.
- No false hazard: same as above but src1_used=0, or EX has mem_read=0 → id_hold=0, no bubble, bubble_count unchanged.
- Stall and flush priority: ex_stall=1 for 3 cycles → ex_* unchanged throughout. Then flush=1 with hazard active → ex_valid=0, bubble_count unchanged, id_hold=0.
- Saturation: 260 consecutive load-use bubbles → bubble_count=255 and stays at 255.
